// File: rtl/kronecker_pkg.sv
// Shared types and widths for the masked Kronecker-delta sequencer.
// Randomness staging for the three AND levels lives here so the wiring is visible in one place.
package kronecker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    S3   = 2'd3
  } kr_state_e;

  localparam int KR_LEVELS  = 3;
  localparam int KR_RND_W   = 6;
  localparam int KR_SHARE_W = 8;
  localparam int KR_IN_W    = 16;
  localparam int KR_OUT_W   = 2;

  // Level 3 reuses r[0]: the datapath ties r1 and r7 to the same wire.
  function automatic logic [KR_RND_W-1:0] kr_level_rand(input kr_state_e st,
                                                        input logic [KR_RND_W-1:0] r);
    logic [KR_RND_W-1:0] v;
    v = '0;
    case (st)
      S1:      v = {2'b00, r[3:0]};
      S2:      v = {r[5:4], 4'b0000};
      S3:      v = {5'b00000, r[0]};
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/kronecker_if.sv
// Handshake and datapath bundle around the Kronecker-delta sequencer.
// slave = the controller; master = whatever drives it (PRNG, producer, datapath, consumer).
interface kronecker_if;
  import kronecker_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [KR_IN_W-1:0]  in_data;
  logic                rnd_valid;
  logic                rnd_ready;
  logic [KR_RND_W-1:0] rnd_data;
  logic [KR_IN_W-1:0]  kr_inp;
  logic [KR_RND_W-1:0] kr_rand;
  logic [KR_OUT_W-1:0] kr_z;
  logic                out_valid;
  logic                out_ready;
  logic [KR_OUT_W-1:0] out_data;
  logic                busy;

  modport slave (
    input  in_valid, in_data, rnd_valid, rnd_data, kr_z, out_ready,
    output in_ready, rnd_ready, kr_inp, kr_rand, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, rnd_valid, rnd_data, kr_z, out_ready,
    input  in_ready, rnd_ready, kr_inp, kr_rand, out_valid, out_data, busy
  );

endinterface

// File: rtl/kronecker_out_fifo.sv
// First-word-fall-through result buffer with occupancy count.
// Read data is forced to zero while empty so nothing stale leaks to the consumer.
module kronecker_out_fifo #(
  parameter int  DEPTH = 2,
  parameter int  WIDTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty_o  = (count_q == '0);
    full_o   = (count_q == CNT_W'(DEPTH));
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
    rdata_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    count_o  = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/kronecker_ctrl.sv
// Sequencer for the d=1 masked Kronecker-delta datapath: stages shares and randomness per AND level,
// precharges idle datapath inputs, and buffers the 2-share result behind valid/ready.
module kronecker_ctrl
  import kronecker_pkg::*;
#(
  parameter int OBUF_DEPTH = 2,
  parameter bit PRECHARGE  = 1'b1
) (
  input logic        clk,
  input logic        rst,
  kronecker_if.slave bus
);

  localparam int CNT_W = $clog2(OBUF_DEPTH + 1);

  kr_state_e           state_q, state_d;
  logic [KR_IN_W-1:0]  data_q, data_d;
  logic [KR_RND_W-1:0] rnd_q, rnd_d;
  logic                cap_pend_q, cap_pend_d;
  logic [KR_IN_W-1:0]  inp_hold_q;
  logic [KR_RND_W-1:0] rand_hold_q;

  logic [CNT_W-1:0]    fifo_count;
  logic [KR_OUT_W-1:0] fifo_rdata;
  logic                fifo_full, fifo_empty, pop;
  logic [1:0]          inflight;
  logic                credit_ok, issue_slot, in_ready, issue;
  logic [KR_IN_W-1:0]  kr_inp;
  logic [KR_RND_W-1:0] kr_rand;

  // A result counts against the buffer from its issue edge until it lands in the FIFO.
  assign inflight  = {1'b0, state_q != IDLE} + {1'b0, cap_pend_q};
  assign credit_ok = (int'(fifo_count) + int'(inflight)) < OBUF_DEPTH;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    rnd_d      = rnd_q;
    cap_pend_d = (state_q == S3);
    issue_slot = !rst && ((state_q == IDLE) || (state_q == S3));
    in_ready   = issue_slot && bus.rnd_valid && credit_ok;
    issue      = in_ready && bus.in_valid;
    kr_inp     = PRECHARGE ? '0 : inp_hold_q;
    kr_rand    = PRECHARGE ? '0 : rand_hold_q;

    case (state_q)
      IDLE: if (issue) state_d = S1;
      S1: begin
        state_d = S2;
        kr_inp  = data_q;
        kr_rand = kr_level_rand(S1, rnd_q);
      end
      S2: begin
        state_d = S3;
        kr_rand = kr_level_rand(S2, rnd_q);
      end
      S3: begin
        state_d = issue ? S1 : IDLE;
        kr_rand = kr_level_rand(S3, rnd_q);
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      data_d = bus.in_data;
      rnd_d  = bus.rnd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      rnd_q       <= '0;
      cap_pend_q  <= 1'b0;
      inp_hold_q  <= '0;
      rand_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      rnd_q       <= rnd_d;
      cap_pend_q  <= cap_pend_d;
      inp_hold_q  <= kr_inp;
      rand_hold_q <= kr_rand;
    end
  end

  kronecker_out_fifo #(
    .DEPTH (OBUF_DEPTH),
    .WIDTH (KR_OUT_W)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cap_pend_q),
    .wdata_i (bus.kr_z),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pop           = !fifo_empty && bus.out_ready;
  assign bus.in_ready  = in_ready;
  assign bus.rnd_ready = issue;
  assign bus.kr_inp    = kr_inp;
  assign bus.kr_rand   = kr_rand;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_rdata;
  assign bus.busy      = (state_q != IDLE) || cap_pend_q || (fifo_count != '0);

  // The credit check is what keeps this from ever firing; there is no overflow path.
  cap_room_a: assert property (@(posedge clk) disable iff (rst) cap_pend_q |-> !fifo_full);

endmodule

// File: tb/tb_kronecker_ctrl.sv
// Bench for kronecker_ctrl paired with a behavioural 3-level DOM-indep AND tree.
// Reference model tracks issue times and outstanding results; expected outputs follow from those.
module tb_kronecker_ctrl;
  import kronecker_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kronecker_if bus_if();

  kronecker_ctrl #(
    .OBUF_DEPTH (DEPTH),
    .PRECHARGE  (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Datapath: 4 + 2 + 1 masked ANDs, one register level each; share0 of ~x is ~inp, share1 is inp.
  logic [1:0] l1 [4] = '{default: 2'b00};
  logic [1:0] l2 [2] = '{default: 2'b00};
  logic [1:0] l3 = 2'b00;

  function automatic logic [1:0] dom_and(input logic a0, a1, b0, b1, r);
    return {(a1 & b1) ^ ((a1 & b0) ^ r), (a0 & b0) ^ ((a0 & b1) ^ r)};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      l1[k] <= dom_and(~bus_if.kr_inp[2*k], bus_if.kr_inp[8+2*k],
                       ~bus_if.kr_inp[2*k+1], bus_if.kr_inp[9+2*k], bus_if.kr_rand[k]);
    for (int j = 0; j < 2; j++)
      l2[j] <= dom_and(l1[2*j][0], l1[2*j][1], l1[2*j+1][0], l1[2*j+1][1], bus_if.kr_rand[4+j]);
    l3 <= dom_and(l2[0][0], l2[0][1], l2[1][0], l2[1][1], bus_if.kr_rand[0]);
  end
  assign bus_if.kr_z = l3;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model state.
  int          last_issue = -100;
  logic [15:0] last_d = '0;
  logic [5:0]  last_r = '0;
  int          q_rdy[$];
  bit          q_z[$];
  logic        rst_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step(input logic rst_v, input logic iv, input logic [15:0] dat,
                      input logic rv, input logic [5:0] rnd, input logic ordy);
    int          age;
    logic        exp_ir, exp_rr, exp_ov;
    logic [15:0] exp_inp;
    logic [5:0]  exp_rand;
    @(negedge clk);
    rst              = rst_v;
    bus_if.in_valid  = iv;
    bus_if.in_data   = dat;
    bus_if.rnd_valid = rv;
    bus_if.rnd_data  = rnd;
    bus_if.out_ready = ordy;
    #1;
    if (rst_v) begin
      if (rst_prev) begin
        chk("rst_in_ready",  32'(bus_if.in_ready),  32'd0);
        chk("rst_rnd_ready", 32'(bus_if.rnd_ready), 32'd0);
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus_if.out_data),  32'd0);
        chk("rst_kr_inp",    32'(bus_if.kr_inp),    32'd0);
        chk("rst_kr_rand",   32'(bus_if.kr_rand),   32'd0);
        chk("rst_busy",      32'(bus_if.busy),      32'd0);
      end
      q_rdy.delete();
      q_z.delete();
      last_issue = -100;
    end else begin
      age      = cyc - last_issue;
      exp_ir   = (age >= 3) && rv && (q_rdy.size() < DEPTH);
      exp_rr   = iv && exp_ir;
      exp_ov   = (q_rdy.size() > 0) && (q_rdy[0] <= cyc);
      exp_inp  = '0;
      exp_rand = '0;
      case (age)
        1: begin exp_inp = last_d; exp_rand = {2'b00, last_r[3:0]}; end
        2: exp_rand = {last_r[5:4], 4'b0000};
        3: exp_rand = {5'b00000, last_r[0]};
        default: ;
      endcase
      chk("in_ready",  32'(bus_if.in_ready),  32'(exp_ir));
      chk("rnd_ready", 32'(bus_if.rnd_ready), 32'(exp_rr));
      chk("out_valid", 32'(bus_if.out_valid), 32'(exp_ov));
      chk("busy",      32'(bus_if.busy),      32'(q_rdy.size() > 0));
      chk("kr_inp",    32'(bus_if.kr_inp),    32'(exp_inp));
      chk("kr_rand",   32'(bus_if.kr_rand),   32'(exp_rand));
      if (exp_ov) begin
        chk("z_xor", 32'(bus_if.out_data[0] ^ bus_if.out_data[1]), 32'(q_z[0]));
        if (ordy) begin
          void'(q_rdy.pop_front());
          void'(q_z.pop_front());
        end
      end
      if (exp_rr) begin
        q_rdy.push_back(cyc + 5);
        q_z.push_back((dat[7:0] ^ dat[15:8]) == 8'h00);
        last_issue = cyc;
        last_d     = dat;
        last_r     = rnd;
      end
    end
    rst_prev = rst_v;
    cyc++;
  endtask

  function automatic logic [15:0] rand_shares();
    logic [7:0] s0, s1;
    s0 = 8'($urandom);
    s1 = ($urandom_range(0, 1) == 1) ? s0 : 8'($urandom);
    return {s1, s0};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 6'h00, 1'b1);
  endtask

  task automatic rand_phase(input int n, input int p_iv, input int p_rv, input int p_or);
    for (int i = 0; i < n; i++)
      step(1'b0, $urandom_range(0, 99) < p_iv, rand_shares(),
           $urandom_range(0, 99) < p_rv, 6'($urandom), $urandom_range(0, 99) < p_or);
  endtask

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.rnd_valid = 1'b0;
    bus_if.rnd_data  = '0;
    bus_if.out_ready = 1'b0;

    // Reset with both request lines high, then issue on the first free cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'hFFFF, 1'b1, 6'h3F, 1'b1);
    step(1'b0, 1'b1, 16'h5A5A, 1'b1, 6'h2B, 1'b1);
    idle(7);
    step(1'b0, 1'b1, 16'h3D3C, 1'b1, 6'h15, 1'b1);
    idle(7);

    // Continuous streaming.
    for (int i = 0; i < 150; i++) step(1'b0, 1'b1, rand_shares(), 1'b1, 6'($urandom), 1'b1);
    idle(6);

    // Consumer stalls: buffer fills, then drains.
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, rand_shares(), 1'b1, 6'($urandom), 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, rand_shares(), 1'b1, 6'($urandom), 1'b1);
    idle(6);

    // PRNG not ready in S3.
    step(1'b0, 1'b1, 16'h0101, 1'b1, 6'h3F, 1'b1);
    step(1'b0, 1'b1, 16'h0202, 1'b1, 6'h01, 1'b1);
    step(1'b0, 1'b1, 16'h0303, 1'b1, 6'h02, 1'b1);
    step(1'b0, 1'b1, 16'h0404, 1'b0, 6'h03, 1'b1);
    idle(6);

    // Reset while the evaluation is in S2: the result must never show up.
    step(1'b0, 1'b1, 16'h7777, 1'b1, 6'h2A, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 6'h00, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 6'h00, 1'b1);
    step(1'b1, 1'b1, 16'h0000, 1'b1, 6'h00, 1'b1);
    idle(10);

    rand_phase(3200, 100, 100, 100);
    rand_phase(1500, 70, 70, 60);
    rand_phase(800, 90, 90, 30);
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
